// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and sizing for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

    localparam int unsigned BUF_DEPTH = 3;
    localparam int unsigned PTR_W     = 2;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned CREDIT_W  = 3;

    typedef logic [PTR_W-1:0]    ptr_t;
    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [CREDIT_W-1:0] credit_t;

    // Advance a buffer pointer, wrapping at BUF_DEPTH (2 -> 0).
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : ptr_t'(p + ptr_t'(1));
    endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Three-entry skid buffer with modulo-3 pointers and registered head/valid/level.
module fifo_rd_stream_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  valid,
    output cnt_t                  level
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_n [BUF_DEPTH];
    ptr_t                  head_q, head_n;
    ptr_t                  tail_q, tail_n;
    cnt_t                  stored_q, stored_n;
    logic [DATA_WIDTH-1:0] head_data_q;
    logic                  valid_q;

    // Next buffer state: clear wins over push/pop; push+pop keeps the count.
    always_comb begin
        mem_n    = mem_q;
        head_n   = head_q;
        tail_n   = tail_q;
        stored_n = stored_q;
        if (clear) begin
            head_n   = '0;
            tail_n   = '0;
            stored_n = '0;
        end else begin
            if (push) begin
                mem_n[tail_q] = push_data;
                tail_n        = ptr_inc(tail_q);
            end
            if (pop) begin
                head_n = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   stored_n = cnt_t'(stored_q + cnt_t'(1));
                2'b01:   stored_n = cnt_t'(stored_q - cnt_t'(1));
                default: stored_n = stored_q;
            endcase
        end
    end

    // State registers; head word and valid are registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            stored_q    <= '0;
            head_data_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            mem_q       <= mem_n;
            head_q      <= head_n;
            tail_q      <= tail_n;
            stored_q    <= stored_n;
            head_data_q <= mem_n[head_n];
            valid_q     <= (stored_n != '0);
        end
    end

    assign head_data = head_data_q;
    assign valid     = valid_q;
    assign level     = stored_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns a registered-read synchronous FIFO into a
// valid/ready stream through a credit-controlled 3-entry skid buffer.
// Optional macro FIFO_RD_STREAM_CHECK_EN compiles in simulation checkers.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rden_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            level_o
);

    logic    inflight_q;
    logic    discard_q;
    cnt_t    level;
    credit_t credit;
    logic    capture;
    logic    pop;

    // Credit counts held words plus the read whose data lands next cycle.
    assign credit      = credit_t'(level) + credit_t'(inflight_q);
    assign fifo_rden_o = rst_n & ~fifo_empty_i & ~flush_i
                       & (credit < credit_t'(BUF_DEPTH));

    // Read data is only sampled the cycle after a read; flush overrides both.
    assign capture = inflight_q & ~discard_q & ~flush_i;
    assign pop     = out_valid_o & out_ready_i & ~flush_i;

    // Track the outstanding read and drop a word landing just after a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            inflight_q <= fifo_rden_o;
            discard_q  <= flush_i & inflight_q;
        end
    end

    fifo_rd_stream_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (fifo_rdata_i),
        .pop       (pop),
        .clear     (flush_i),
        .head_data (out_data_o),
        .valid     (out_valid_o),
        .level     (level)
    );

    assign level_o = level;

`ifdef FIFO_RD_STREAM_CHECK_EN
    logic                  stall_q;
    logic                  flush_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Remember last cycle's stall/flush state for the handshake check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
            flush_q <= 1'b0;
            data_q  <= '0;
        end else begin
            stall_q <= out_valid_o & ~out_ready_i;
            flush_q <= flush_i;
            data_q  <= out_data_o;
        end
    end

    // Protocol checkers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (fifo_rden_o && fifo_empty_i)
                $error("fifo_rd_stream: read issued while FIFO empty");
            if (capture && (level == cnt_t'(BUF_DEPTH)))
                $error("fifo_rd_stream: capture into full buffer");
            if (stall_q && !flush_q && (!out_valid_o || (out_data_o != data_q)))
                $error("fifo_rd_stream: output changed while stalled");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a registered-read FIFO model.
module tb_fifo_rd_stream;

    logic        clk;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_rden;
    logic [31:0] fifo_rdata;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  level;

    int n_asserts = 0;
    int n_fail    = 0;

    // FIFO model: writes from the stimulus, reads from the DUT.
    logic [31:0] fifo_mem [256];
    int          push_cnt = 0;
    int          pop_cnt;
    logic        empty_mask;
    int          rd_base;
    logic [7:0]  exp_word;

    fifo_rd_stream #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty_i (fifo_empty),
        .fifo_rden_o  (fifo_rden),
        .fifo_rdata_i (fifo_rdata),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .level_o      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = empty_mask | (push_cnt == pop_cnt);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_cnt    <= push_cnt;
            fifo_rdata <= '0;
        end else if (fifo_rden) begin
            fifo_rdata <= fifo_mem[pop_cnt % 256];
            pop_cnt    <= pop_cnt + 1;
        end
    end

    task automatic push(input logic [31:0] w);
        fifo_mem[push_cnt % 256] = w;
        push_cnt = push_cnt + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        empty_mask = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_rden",  32'(fifo_rden), 32'd0);
        check("rst_level", 32'(level),     32'd0);
        check("rst_data",  out_data,       32'd0);

        // Fill and drain at full rate
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(32'h11 + 32'(i));
        #1;
        for (int k = 0; k < 12; k++) begin
            check("fd_rden",  32'(fifo_rden), (k < 8) ? 32'd1 : 32'd0);
            check("fd_valid", 32'(out_valid), (k >= 2 && k < 10) ? 32'd1 : 32'd0);
            if (k >= 2 && k < 10) check("fd_data", out_data, 32'h11 + 32'(k - 2));
            @(negedge clk); #1;
        end

        // Backpressure: only three reads while stalled
        out_ready = 1'b0;
        rd_base   = pop_cnt;
        for (int i = 0; i < 5; i++) push(32'h21 + 32'(i));
        repeat (6) @(negedge clk);
        #1;
        check("bp_level", 32'(level),          32'd3);
        check("bp_rden",  32'(fifo_rden),      32'd0);
        check("bp_valid", 32'(out_valid),      32'd1);
        check("bp_data",  out_data,            32'h21);
        check("bp_reads", 32'(pop_cnt - rd_base), 32'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_valid", 32'(out_valid), 32'd1);
            check("bp_drain_data",  out_data,       32'h21 + 32'(i));
            @(negedge clk); #1;
        end
        check("bp_empty_valid", 32'(out_valid), 32'd0);

        // Wrap: alternating ready over 20 words
        @(negedge clk);
        for (int i = 0; i < 20; i++) push(32'h40 + 32'(i));
        exp_word = 8'h40;
        for (int c = 0; c < 100 && exp_word < 8'h54; c++) begin
            out_ready = (c % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                check("wrap_data", out_data, 32'(exp_word));
                exp_word = exp_word + 8'd1;
            end
            @(negedge clk);
        end
        check("wrap_count", 32'(exp_word), 32'h54);

        // Flush with a read in flight and two words held
        out_ready = 1'b0;
        push(32'h61); push(32'h62);
        repeat (4) @(negedge clk);
        #1;
        check("fl_pre_level", 32'(level), 32'd2);
        push(32'h63);
        @(negedge clk);
        flush = 1'b1;
        push(32'h64);
        #1;
        check("fl_rden_in_flush", 32'(fifo_rden), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_level", 32'(level),     32'd0);
        check("fl_rden",  32'(fifo_rden), 32'd1);
        @(negedge clk); #1;
        check("fl_drop_valid", 32'(out_valid), 32'd0);
        check("fl_drop_level", 32'(level),     32'd0);
        @(negedge clk); #1;
        check("fl_next_valid", 32'(out_valid), 32'd1);
        check("fl_next_data",  out_data,       32'h64);
        check("fl_next_level", 32'(level),     32'd1);
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("fl_end_valid", 32'(out_valid), 32'd0);

        // Mid-operation asynchronous reset
        for (int i = 0; i < 16; i++) push(32'h70 + 32'(i));
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_rden",  32'(fifo_rden), 32'd0);
        check("mr_level", 32'(level),     32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        push(32'hA0); push(32'hA1);
        #1;
        check("mr_rden0", 32'(fifo_rden), 32'd1);
        @(negedge clk); #1;
        check("mr_rden1",  32'(fifo_rden), 32'd1);
        check("mr_valid1", 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        check("mr_valid2", 32'(out_valid), 32'd1);
        check("mr_data2",  out_data,       32'hA0);
        check("mr_rden2",  32'(fifo_rden), 32'd0);
        @(negedge clk); #1;
        check("mr_valid3", 32'(out_valid), 32'd1);
        check("mr_data3",  out_data,       32'hA1);
        @(negedge clk); #1;
        check("mr_valid4", 32'(out_valid), 32'd0);

        // Empty toggling every cycle
        @(negedge clk);
        for (int i = 0; i < 6; i++) push(32'h80 + 32'(i));
        exp_word = 8'h80;
        for (int c = 0; c < 60 && exp_word < 8'h86; c++) begin
            empty_mask = (c % 2 == 1);
            #1;
            check("et_no_rd_empty", 32'(fifo_rden & fifo_empty), 32'd0);
            if (out_valid && out_ready) begin
                check("et_data", out_data, 32'(exp_word));
                exp_word = exp_word + 8'd1;
            end
            @(negedge clk);
        end
        empty_mask = 1'b0;
        check("et_count", 32'(exp_word), 32'h86);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
